// File: rtl/keccak_squeeze_unit_if.sv
// Shared Keccak widths plus the squeeze-stage port bundle.
// The engine controller uses the master modport and the squeeze unit uses the slave modport.
package keccak_pkg;
    localparam int ROW_SIZE          = 5;
    localparam int COL_SIZE          = 5;
    localparam int LANE_SIZE         = 64;
    localparam int MAX_OUTPUT_DWIDTH = 256;
    localparam int RATE_WIDTH        = 11;
    localparam int BYTE_ABSORB_WIDTH = 8;
    localparam int MODE_SEL_WIDTH    = 3;

    typedef enum logic [MODE_SEL_WIDTH-1:0] {
        SHA3_224 = 3'd0,
        SHA3_256 = 3'd1,
        SHA3_384 = 3'd2,
        SHA3_512 = 3'd3,
        SHAKE128 = 3'd4,
        SHAKE256 = 3'd5
    } keccak_mode_e;
endpackage

interface keccak_squeeze_if;
    import keccak_pkg::*;

    logic                           valid_i;
    logic [LANE_SIZE-1:0]           state_array_i [ROW_SIZE][COL_SIZE];
    logic [MODE_SEL_WIDTH-1:0]      keccak_mode_i;
    logic [RATE_WIDTH-1:0]          rate_i;
    logic [BYTE_ABSORB_WIDTH-1:0]   bytes_squeezed_i;
    logic                           valid_o;
    logic [BYTE_ABSORB_WIDTH-1:0]   bytes_squeezed_o;
    logic                           squeeze_perm_needed_o;
    logic [MAX_OUTPUT_DWIDTH-1:0]   data_o;
    logic [MAX_OUTPUT_DWIDTH/8-1:0] keep_o;
    logic                           last_o;

    modport master (
        output valid_i, state_array_i, keccak_mode_i, rate_i, bytes_squeezed_i,
        input  valid_o, bytes_squeezed_o, squeeze_perm_needed_o, data_o, keep_o, last_o
    );

    modport slave (
        input  valid_i, state_array_i, keccak_mode_i, rate_i, bytes_squeezed_i,
        output valid_o, bytes_squeezed_o, squeeze_perm_needed_o, data_o, keep_o, last_o
    );
endinterface

// File: rtl/keccak_squeeze_unit.sv
// Keccak squeeze output stage: slices a 32-byte window from the state at the current offset, registered.
// Optional macro SQUEEZE_ZERO_UNKEPT_EN zeroes data bytes whose keep bit is clear.
module keccak_squeeze_unit
    import keccak_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    keccak_squeeze_if.slave  sq
);
    localparam int STATE_BYTES = 200;
    localparam int OUT_BYTES   = MAX_OUTPUT_DWIDTH / 8;

    logic [7:0]                     state_bytes_s [STATE_BYTES];
    logic [8:0]                     off_s;
    logic [8:0]                     rate_bytes_s;
    logic [8:0]                     rate_rem_s;
    logic [8:0]                     dig_len_s;
    logic [8:0]                     dig_rem_s;
    logic [8:0]                     n_s;
    logic [8:0]                     end_s;
    logic                           is_sha3_s;
    logic [OUT_BYTES-1:0]           keep_s;
    logic [MAX_OUTPUT_DWIDTH-1:0]   data_s;
    logic                           last_s;
    logic                           perm_s;
    logic [BYTE_ABSORB_WIDTH-1:0]   next_off_s;

    logic                           valid_d, valid_q;
    logic [MAX_OUTPUT_DWIDTH-1:0]   data_d, data_q;
    logic [OUT_BYTES-1:0]           keep_d, keep_q;
    logic                           last_d, last_q;
    logic                           perm_d, perm_q;
    logic [BYTE_ABSORB_WIDTH-1:0]   off_d, off_q;

    // Flatten the lane array into linear byte order B = 8*(5*y + x) + i.
    always_comb begin
        for (int x = 0; x < ROW_SIZE; x++) begin
            for (int y = 0; y < COL_SIZE; y++) begin
                for (int i = 0; i < 8; i++) begin
                    state_bytes_s[8*(5*y + x) + i] = sq.state_array_i[x][y][8*i +: 8];
                end
            end
        end
    end

    // Valid-byte count, digest/rate boundary flags and next offset.
    always_comb begin
        off_s        = {1'b0, sq.bytes_squeezed_i};
        rate_bytes_s = {1'b0, sq.rate_i[RATE_WIDTH-1:3]};
        case (keccak_mode_e'(sq.keccak_mode_i))
            SHA3_224: begin dig_len_s = 9'd28; is_sha3_s = 1'b1; end
            SHA3_256: begin dig_len_s = 9'd32; is_sha3_s = 1'b1; end
            SHA3_384: begin dig_len_s = 9'd48; is_sha3_s = 1'b1; end
            SHA3_512: begin dig_len_s = 9'd64; is_sha3_s = 1'b1; end
            default:  begin dig_len_s = 9'd0;  is_sha3_s = 1'b0; end
        endcase
        if (off_s >= rate_bytes_s) begin
            rate_rem_s = 9'd0;
        end else begin
            rate_rem_s = rate_bytes_s - off_s;
        end
        if (off_s >= dig_len_s) begin
            dig_rem_s = 9'd0;
        end else begin
            dig_rem_s = dig_len_s - off_s;
        end
        if (rate_rem_s < 9'd32) begin
            n_s = rate_rem_s;
        end else begin
            n_s = 9'd32;
        end
        // A spent digest (dig_rem = 0) no longer limits the window.
        if (is_sha3_s && (dig_rem_s != 9'd0) && (dig_rem_s < n_s)) begin
            n_s = dig_rem_s;
        end else begin
            n_s = n_s;
        end
        end_s      = off_s + n_s;
        last_s     = is_sha3_s && (end_s >= dig_len_s);
        perm_s     = (end_s >= rate_bytes_s);
        next_off_s = perm_s ? 8'd0 : end_s[7:0];
    end

    // Output window and keep mask; positions past the state read as zero.
    always_comb begin
        keep_s = '0;
        data_s = '0;
        for (int k = 0; k < OUT_BYTES; k++) begin
            keep_s[k] = (n_s > 9'(k));
            if ((off_s + 9'(k)) < 9'(STATE_BYTES)) begin
                data_s[8*k +: 8] = state_bytes_s[8'(off_s + 9'(k))];
            end else begin
                data_s[8*k +: 8] = 8'h00;
            end
`ifdef SQUEEZE_ZERO_UNKEPT_EN
            if (!keep_s[k]) begin
                data_s[8*k +: 8] = 8'h00;
            end else begin
                data_s[8*k +: 8] = data_s[8*k +: 8];
            end
`endif
        end
    end

    // Load on valid_i, otherwise hold everything except valid.
    always_comb begin
        valid_d = sq.valid_i;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        perm_d  = perm_q;
        off_d   = off_q;
        if (sq.valid_i) begin
            data_d = data_s;
            keep_d = keep_s;
            last_d = last_s;
            perm_d = perm_s;
            off_d  = next_off_s;
        end else begin
            data_d = data_q;
        end
    end

    // Output register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            perm_q  <= 1'b0;
            off_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            perm_q  <= perm_d;
            off_q   <= off_d;
        end
    end

    assign sq.valid_o               = valid_q;
    assign sq.data_o                = data_q;
    assign sq.keep_o                = keep_q;
    assign sq.last_o                = last_q;
    assign sq.squeeze_perm_needed_o = perm_q;
    assign sq.bytes_squeezed_o      = off_q;
endmodule

// File: tb/tb_keccak_squeeze_unit.sv
// Self-checking bench for keccak_squeeze_unit: directed beats plus randomized beats against a byte-level model.
// Honours SQUEEZE_ZERO_UNKEPT_EN in the expected data.
module tb_keccak_squeeze_unit;
    logic clk = 1'b0;
    logic rst;

    keccak_squeeze_if sq_if();

    keccak_squeeze_unit dut (
        .clk (clk),
        .rst (rst),
        .sq  (sq_if)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  mem [200];
    int          rates [6] = '{1152, 1088, 832, 576, 1344, 1088};

    logic [255:0] exp_data;
    logic [31:0]  exp_keep;
    logic         exp_last;
    logic         exp_perm;
    logic [7:0]   exp_next;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic push_state();
        for (int b = 0; b < 200; b++) begin
            sq_if.state_array_i[(b / 8) % 5][(b / 8) / 5][8*(b % 8) +: 8] = mem[b];
        end
    endtask

    task automatic fill_pattern();
        for (int b = 0; b < 200; b++) mem[b] = 8'(b);
        push_state();
    endtask

    task automatic fill_random();
        for (int b = 0; b < 200; b++) mem[b] = 8'($urandom_range(0, 255));
        push_state();
    endtask

    // Expected beat straight from the byte-offset arithmetic of the squeeze rules.
    task automatic model(input int mode, input int rate, input int off);
        int  rb, rr, d, dr, n, b;
        bit  sha3;
        rb   = rate / 8;
        rr   = (off >= rb) ? 0 : rb - off;
        case (mode)
            0: d = 28;
            1: d = 32;
            2: d = 48;
            3: d = 64;
            default: d = 0;
        endcase
        sha3 = (mode <= 3);
        dr   = (d > off) ? d - off : 0;
        n    = (rr < 32) ? rr : 32;
        if (sha3 && dr > 0 && dr < n) n = dr;
        exp_keep = 32'd0;
        exp_data = 256'd0;
        for (int k = 0; k < 32; k++) begin
            b = off + k;
            if (k < n) exp_keep[k] = 1'b1;
            if (b < 200) exp_data[8*k +: 8] = mem[b];
`ifdef SQUEEZE_ZERO_UNKEPT_EN
            if (k >= n) exp_data[8*k +: 8] = 8'h00;
`endif
        end
        exp_last = sha3 && (off + n >= d);
        exp_perm = (off + n >= rb);
        exp_next = exp_perm ? 8'd0 : 8'(off + n);
    endtask

    task automatic check_beat(input string tag);
        check({tag, ".valid"}, 256'(sq_if.valid_o), 256'd1);
        check({tag, ".data"},  sq_if.data_o, exp_data);
        check({tag, ".keep"},  256'(sq_if.keep_o), 256'(exp_keep));
        check({tag, ".last"},  256'(sq_if.last_o), 256'(exp_last));
        check({tag, ".perm"},  256'(sq_if.squeeze_perm_needed_o), 256'(exp_perm));
        check({tag, ".next"},  256'(sq_if.bytes_squeezed_o), 256'(exp_next));
    endtask

    task automatic beat(input string tag, input int mode, input int rate, input int off);
        @(negedge clk);
        sq_if.valid_i          = 1'b1;
        sq_if.keccak_mode_i    = 3'(mode);
        sq_if.rate_i           = 11'(rate);
        sq_if.bytes_squeezed_i = 8'(off);
        @(posedge clk);
        #1;
        sq_if.valid_i = 1'b0;
        model(mode, rate, off);
        check_beat(tag);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".valid"}, 256'(sq_if.valid_o), 256'd0);
        check({tag, ".data"},  sq_if.data_o, 256'd0);
        check({tag, ".keep"},  256'(sq_if.keep_o), 256'd0);
        check({tag, ".last"},  256'(sq_if.last_o), 256'd0);
        check({tag, ".perm"},  256'(sq_if.squeeze_perm_needed_o), 256'd0);
        check({tag, ".next"},  256'(sq_if.bytes_squeezed_o), 256'd0);
    endtask

    initial begin
        int mode, rate, off;
        rst                    = 1'b1;
        sq_if.valid_i          = 1'b0;
        sq_if.keccak_mode_i    = 3'd0;
        sq_if.rate_i           = 11'd0;
        sq_if.bytes_squeezed_i = 8'd0;
        fill_pattern();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Directed beats on the linear byte pattern.
        beat("sha256_o0", 1, 1088, 0);
        check("sha256_o0.keep_lit", 256'(sq_if.keep_o), 256'h0FFFF_FFFF & 256'hFFFF_FFFF);
        check("sha256_o0.next_lit", 256'(sq_if.bytes_squeezed_o), 256'd32);
        check("sha256_o0.byte31",   256'(sq_if.data_o[255:248]), 256'h1F);
        beat("sha512_o0", 3, 576, 0);
        check("sha512_o0.last_lit", 256'(sq_if.last_o), 256'd0);
        beat("sha512_o32", 3, 576, 32);
        check("sha512_o32.byte0", 256'(sq_if.data_o[7:0]), 256'h20);
        beat("sha512_o64", 3, 576, 64);
        check("sha512_o64.keep_lit", 256'(sq_if.keep_o), 256'hFF);
        check("sha512_o64.perm_lit", 256'(sq_if.squeeze_perm_needed_o), 256'd1);
        check("sha512_o64.byte7",    256'(sq_if.data_o[63:56]), 256'h47);
        beat("shake128_o0", 4, 1344, 0);
        beat("shake128_o160", 4, 1344, 160);
        check("shake128_o160.keep_lit", 256'(sq_if.keep_o), 256'hFF);
        beat("sha224_o0", 0, 1152, 0);
        check("sha224_o0.keep_lit", 256'(sq_if.keep_o), 256'h0FFF_FFFF);
        beat("sha384_o48", 2, 832, 48);
        beat("unknown_o100", 7, 1088, 100);
        beat("shake256_o190", 5, 1088, 190);

        // valid_i low: valid drops, everything else holds despite changed inputs.
        @(negedge clk);
        sq_if.keccak_mode_i    = 3'd2;
        sq_if.bytes_squeezed_i = 8'd5;
        fill_random();
        @(posedge clk);
        #1;
        check("hold.valid", 256'(sq_if.valid_o), 256'd0);
        check("hold.data",  sq_if.data_o, exp_data);
        check("hold.keep",  256'(sq_if.keep_o), 256'(exp_keep));
        check("hold.last",  256'(sq_if.last_o), 256'(exp_last));
        check("hold.perm",  256'(sq_if.squeeze_perm_needed_o), 256'(exp_perm));
        check("hold.next",  256'(sq_if.bytes_squeezed_o), 256'(exp_next));

        // Randomized beats.
        for (int it = 0; it < 40; it++) begin
            fill_random();
            mode = $urandom_range(0, 7);
            rate = (mode < 6) ? rates[mode] : rates[$urandom_range(0, 5)];
            off  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, rate / 8);
            beat($sformatf("rnd%0d_m%0d_o%0d", it, mode, off), mode, rate, off);
        end

        // Reset together with valid_i wins.
        beat("pre_rst", 1, 1088, 0);
        @(negedge clk);
        rst                    = 1'b1;
        sq_if.valid_i          = 1'b1;
        sq_if.keccak_mode_i    = 3'd3;
        sq_if.rate_i           = 11'd576;
        sq_if.bytes_squeezed_i = 8'd0;
        @(posedge clk);
        #1;
        check_zero("rst_valid");
        @(negedge clk);
        rst           = 1'b0;
        sq_if.valid_i = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/keccak_squeeze_unit.md
# keccak_squeeze_unit

Output stage of the Keccak engine's squeeze phase. Each cycle it can slice a 32-byte window out of the 1600-bit state at the current squeeze offset, then register the window, its byte-keep mask, end-of-digest flag, permutation request and next offset. It sits between the permutation core's state register and the AXI-Stream-style output port. The engine controller feeds the returned offset back on the next beat.

## Interface
- Parameters: none; all widths come from `keccak_pkg`:
  - ROW_SIZE = 5, COL_SIZE = 5, LANE_SIZE = 64
  - MAX_OUTPUT_DWIDTH = 256
  - RATE_WIDTH, BYTE_ABSORB_WIDTH (8)
  - MODE_SEL_WIDTH; mode enum SHA3_224, SHA3_256, SHA3_384, SHA3_512, SHAKE128, SHAKE256
- One clock; reset is synchronous and active-high.
- Ports:
  - clk  in  1  clock
  - rst  in  1  synchronous active-high reset
  - valid_i  in  1  sample the inputs this cycle
  - state_array_i  in  [5][5][64]  Keccak state, indexed [x][y]
  - keccak_mode_i  in  MODE_SEL_WIDTH  algorithm select
  - rate_i  in  RATE_WIDTH  rate in bits (1152/1088/832/576/1344/1088)
  - bytes_squeezed_i  in  BYTE_ABSORB_WIDTH  byte offset into the current rate block
  - valid_o  out  1  outputs below are valid
  - bytes_squeezed_o  out  BYTE_ABSORB_WIDTH  next offset
  - squeeze_perm_needed_o  out  1  rate block exhausted; permute before the next beat
  - data_o  out  256  output window, byte 0 in bits [7:0]
  - keep_o  out  32  valid-byte mask, LSB-aligned
  - last_o  out  1  final beat of a fixed-length digest

## Operation
- Linear state byte index: `B = 8*(5*y + x) + i`, where i is the little-endian byte within lane [x][y].
- Data: `data_o byte k = state byte (bytes_squeezed_i + k)`, for k = 0..31.
  - Any index ≥ 200 gives 0x00.
- Rate remainder: `rate_rem = rate_i/8 − bytes_squeezed_i`.
  - If bytes_squeezed_i ≥ rate_i/8, rate_rem = 0.
- Digest length D = 28/32/48/64 bytes for SHA3-224/256/384/512.
  - `dig_rem = D − bytes_squeezed_i`, saturating at 0.
- Valid count n:
  - SHA3 modes with dig_rem > 0: `n = min(32, rate_rem, dig_rem)`.
  - Otherwise: `n = min(32, rate_rem)`.
- `keep_o = (1<<n) − 1`; n = 32 gives all ones.
- `last_o = 1` iff the mode is SHA3 and `bytes_squeezed_i + n ≥ D`.
  - SHAKE modes never assert last_o.
- `squeeze_perm_needed_o = 1` iff `bytes_squeezed_i + n ≥ rate_i/8`.
- `bytes_squeezed_o = squeeze_perm_needed_o ? 0 : bytes_squeezed_i + n`.
- Unknown mode encodings behave like SHAKE: no last_o.

## Timing
- Single registered stage; latency is 1 cycle from valid_i to valid_o.
- On a clock edge with valid_i = 1, all outputs load from the combinational computation above, and valid_o ← 1.
- On a clock edge with valid_i = 0: valid_o ← 0 and the other outputs hold their values.
- No backpressure. The controller must not raise valid_i until it has consumed the previous result.
- Reset wins over valid_i in the same cycle. A mid-operation reset drops any in-flight beat.
- Reset values: every output is 0:
  - valid_o, data_o, keep_o, last_o, squeeze_perm_needed_o, bytes_squeezed_o

## Configuration
- `SQUEEZE_ZERO_UNKEPT_EN`:
  - Defined: data_o bytes whose keep_o bit is 0 are forced to 0x00.
  - Undefined (default): data_o always carries the raw state bytes for all 32 positions, regardless of keep_o.

## Test plan
State holds a linear pattern: state byte B = B mod 256. Each check is made one cycle after valid_i.
- **SHA3-256, rate 1088, offset 0:** data = bytes 0x00..0x1F, keep = 0xFFFFFFFF, last = 1, perm = 0, next offset = 32.
- **SHA3-512, rate 576, two beats:**
  - Offset 0: bytes 0x00..0x1F, keep all ones, last = 0, perm = 0.
  - Offset 32: bytes 0x20..0x3F, keep all ones, last = 1, perm = 0.
- **SHA3-512 at offset 64:**
  - Default build: data = bytes 0x40..0x5F, keep = 0x000000FF, last = 1, perm = 1, next offset = 0.
  - With `SQUEEZE_ZERO_UNKEPT_EN`: data bytes 8..31 = 0.
- **SHAKE128, rate 1344:**
  - Offset 0: last = 0, keep all ones.
  - Offset 160: keep = 0xFF, perm = 1, next offset = 0, last = 0.
- **SHA3-224, rate 1152, offset 0:** keep = 0x0FFFFFFF, last = 1.
- **Control:**
  - rst asserted together with valid_i → all outputs 0 next cycle.
  - valid_i low → valid_o drops and the other outputs hold.
